mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit.sv | 183 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Execute-stage multiply/divide unit with HI/LO registers.
//                Runs MULT/MULTU/DIV/DIVU over a fixed latency. The result
//                is computed at issue into pending registers and is committed
//                to HI/LO when the busy countdown expires. MTHI/MTLO write
//                HI/LO directly in one edge while the unit is idle.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1   clock, rising edge
//    reset      in   1   asynchronous active-high reset
//    start      in   1   issue strobe for the operation on op
//    op         in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO,
//                        6/7 reserved (no effect)
//    A          in  32   rs operand (post-forwarding)
//    B          in  32   rt operand (post-forwarding)
//    busy       out  1   multi-cycle operation in flight
//    stall_req  out  1   busy, or a multiply/divide issuing this cycle
//    HI         out 32   current HI register
//    LO         out 32   current LO register
// ============================================================================
module mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    // Counter is wide enough for the longer latency, and never below 4 bits.
    localparam int c_MAX_CYC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int c_CLOG     = $clog2(c_MAX_CYC + 1);
    localparam int c_CNT_W    = (c_CLOG > 4) ? c_CLOG : 4;

    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = MUL_CYCLES[c_CNT_W-1:0];
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = DIV_CYCLES[c_CNT_W-1:0];
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = {{(c_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [31:0]          r_pendHi;
    logic [31:0]          r_pendLo;
    logic                 r_divZero;
    logic                 r_busy;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;

    // ------------------------------------------------------------------
    // Multiply: both products are formed on 64-bit extended operands so
    // the low 64 bits are exact for signed and unsigned alike.
    // ------------------------------------------------------------------
    logic [63:0] w_prodSigned;
    logic [63:0] w_prodUnsigned;
    logic [63:0] w_prod;

    assign w_prodSigned   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prodUnsigned = {32'd0, A} * {32'd0, B};
    assign w_prod         = (op == c_OP_MULT) ? w_prodSigned : w_prodUnsigned;

    // ------------------------------------------------------------------
    // Divide: magnitude division with sign fix-up. Quotient truncates
    // toward zero; remainder follows the dividend sign. The magnitude of
    // 0x80000000 is representable as unsigned, so the overflow case
    // 0x80000000 / -1 naturally yields 0x80000000 remainder 0.
    // ------------------------------------------------------------------
    logic        w_divSigned;
    logic        w_negA;
    logic        w_negB;
    logic [31:0] w_magA;
    logic [31:0] w_magB;
    logic        w_bZero;
    logic [31:0] w_divisor;
    logic [31:0] w_uQuot;
    logic [31:0] w_uRem;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_divSigned = (op == c_OP_DIV);
    assign w_negA      = w_divSigned & A[31];
    assign w_negB      = w_divSigned & B[31];
    assign w_magA      = w_negA ? (~A + 32'd1) : A;
    assign w_magB      = w_negB ? (~B + 32'd1) : B;
    assign w_bZero     = (B == 32'd0);
    // Substitute a divisor of one so no divide-by-zero is ever evaluated;
    // that result is discarded at commit anyway.
    assign w_divisor   = w_bZero ? 32'd1 : w_magB;
    assign w_uQuot     = w_magA / w_divisor;
    assign w_uRem      = w_magA % w_divisor;
    assign w_quot      = (w_negA ^ w_negB) ? (~w_uQuot + 32'd1) : w_uQuot;
    assign w_rem       = w_negA ? (~w_uRem + 32'd1) : w_uRem;

    // ------------------------------------------------------------------
    // Control FSM, counter, pending result and architectural HI/LO.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= c_CNT_ZERO;
            r_pendHi  <= 32'd0;
            r_pendLo  <= 32'd0;
            r_divZero <= 1'b0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            c_OP_MULT, c_OP_MULTU: begin
                                r_pendHi <= w_prod[63:32];
                                r_pendLo <= w_prod[31:0];
                                r_cnt    <= c_MUL_LOAD;
                                r_busy   <= 1'b1;
                                r_state  <= MUL;
                            end
                            c_OP_DIV, c_OP_DIVU: begin
                                r_pendHi  <= w_rem;
                                r_pendLo  <= w_quot;
                                r_divZero <= w_bZero;
                                r_cnt     <= c_DIV_LOAD;
                                r_busy    <= 1'b1;
                                r_state   <= DIV;
                            end
                            c_OP_MTHI: r_hi <= A;
                            c_OP_MTLO: r_lo <= A;
                            default: ;
                        endcase
                    end
                end

                MUL, DIV: begin
                    // Any start seen here is ignored: only the countdown runs.
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        if (!((r_state == DIV) && r_divZero)) begin
                            r_hi <= r_pendHi;
                            r_lo <= r_pendLo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign stall_req = r_busy | (start & ~op[2]);
    assign HI        = r_hi;
    assign LO        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div_unit
//  Description : Directed self-checking bench for mul_div_unit with
//                hand-computed expected values. Inputs change and outputs
//                are sampled on the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        stall_req;
    logic [31:0] HI;
    logic [31:0] LO;

    int nVec = 0;
    int nErr = 0;

    mul_div_unit #(
        .MUL_CYCLES (5),
        .DIV_CYCLES (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .stall_req (stall_req),
        .HI        (HI),
        .LO        (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge: drives an op for one cycle, checks the
    // combinational stall request, and returns on the next falling edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic expStall);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        #1;
        chk("stall_at_issue", 32'(stall_req), 32'(expStall));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Busy window: busy and stall high, HI/LO still showing the old values.
    task automatic waitBusy(input int n, input logic [31:0] hiOld, input logic [31:0] loOld);
        for (int i = 0; i < n; i++) begin
            chk("busy_during", 32'(busy), 32'd1);
            chk("stall_during", 32'(stall_req), 32'd1);
            chk("hi_during", HI, hiOld);
            chk("lo_during", LO, loOld);
            @(negedge clk);
        end
    endtask

    task automatic chkDone(input string tag, input logic [31:0] expHi, input logic [31:0] expLo);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_stall"}, 32'(stall_req), 32'd0);
        chk({tag, "_hi"}, HI, expHi);
        chk({tag, "_lo"}, LO, expLo);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chkDone("reset", 32'h0, 32'h0);

        // MULT -2 * 3
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1);
        waitBusy(5, 32'h0, 32'h0);
        chkDone("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // MULTU 0xFFFFFFFF^2
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        waitBusy(5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        chkDone("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        // DIV -7 / 2
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        waitBusy(10, 32'hFFFF_FFFE, 32'h0000_0001);
        chkDone("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // DIV 7 / -2: quotient -3, remainder +1 (dividend sign)
        issue(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b1);
        waitBusy(10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        chkDone("div_negb", 32'h0000_0001, 32'hFFFF_FFFD);

        // DIV overflow 0x80000000 / -1
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        waitBusy(10, 32'h0000_0001, 32'hFFFF_FFFD);
        chkDone("div_ovf", 32'h0, 32'h8000_0000);

        // DIVU 0xFFFFFFF9 / 2 (unsigned)
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
        waitBusy(10, 32'h0, 32'h8000_0000);
        chkDone("divu", 32'h0000_0001, 32'h7FFF_FFFC);

        // MTHI / MTLO then DIVU by zero leaves HI/LO unchanged
        issue(3'd4, 32'h0000_1234, 32'd0, 1'b0);
        chkDone("mthi", 32'h0000_1234, 32'h7FFF_FFFC);
        issue(3'd5, 32'h0000_5678, 32'd0, 1'b0);
        chkDone("mtlo", 32'h0000_1234, 32'h0000_5678);
        issue(3'd3, 32'd7, 32'd0, 1'b1);
        waitBusy(10, 32'h0000_1234, 32'h0000_5678);
        chkDone("divz", 32'h0000_1234, 32'h0000_5678);

        // MTLO while idle
        issue(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
        chkDone("mtlo2", 32'h0000_1234, 32'hDEAD_BEEF);

        // Reserved op: no effect
        issue(3'd6, 32'hAAAA_AAAA, 32'd5, 1'b0);
        chkDone("rsvd", 32'h0000_1234, 32'hDEAD_BEEF);

        // DIV 100 / 7 with operand changes and an MTHI issued mid-busy
        issue(3'd2, 32'd100, 32'd7, 1'b1);
        A = 32'd5;
        B = 32'd1;
        for (int i = 0; i < 10; i++) begin
            chk("busy_ign", 32'(busy), 32'd1);
            chk("hi_ign", HI, 32'h0000_1234);
            if (i == 2) begin
                start = 1'b1;
                op    = 3'd4;
                A     = 32'd1;
            end
            if (i == 3) start = 1'b0;
            @(negedge clk);
        end
        chkDone("div_ign", 32'd2, 32'd14);

        // Asynchronous reset in busy cycle 4 of a DIV
        issue(3'd2, 32'd9, 32'd3, 1'b1);
        repeat (3) @(negedge clk);
        chk("busy_pre_rst", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chkDone("post_rst", 32'h0, 32'h0);

        // Back-to-back: MULT 2*3 then MULTU 4*5 right after busy falls
        issue(3'd0, 32'd2, 32'd3, 1'b1);
        waitBusy(5, 32'h0, 32'h0);
        chk("b2b_busy0", 32'(busy), 32'd0);
        chk("b2b_lo1", LO, 32'd6);
        chk("b2b_hi1", HI, 32'd0);
        issue(3'd1, 32'd4, 32'd5, 1'b1);
        waitBusy(5, 32'h0, 32'd6);
        chkDone("b2b2", 32'h0, 32'd20);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire
